rename_map_table: RTL
=====================

Name: rename_map_table

Overview:
- Superscalar successor of the single-lane map table: renames DISP_W instructions per cycle and takes CDB_W broadcasts per cycle.
- Holds CKPT_N internal branch checkpoints, so no external branch-stack copy is needed.
- Checkpoint recovery takes one cycle and selects the checkpoint by ID.
- Sits between decode/free-list and RS/ROB; resolve inputs come from the branch unit.

Parameters:
AREG_N, 32, architectural registers; areg 0 is hardwired to zero
PREG_N, 64, physical registers; PREG_W = $clog2(PREG_N)
DISP_W, 2, dispatch lanes per cycle
CDB_W, 2, CDB broadcast ports
CKPT_N, 4, checkpoint slots; CK_W = $clog2(CKPT_N)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
disp_en_i  in  1  dispatch group valid (only honoured when disp_ready_o)
lane_vld_i  in  DISP_W  per-lane instruction valid
opa_areg_i, opb_areg_i  in  DISP_W x AREG_W  source aregs
dest_areg_i  in  DISP_W x AREG_W  destination areg
dest_wr_i  in  DISP_W  lane writes a destination
new_preg_i  in  DISP_W x PREG_W  free-list pregs
br_vld_i  in  1  group contains one branch needing a checkpoint
br_lane_i  in  LANE_W  lane index of that branch
opa_preg_o, opb_preg_o  out  DISP_W x PREG_W  renamed sources
opa_rdy_o, opb_rdy_o  out  DISP_W  source ready bits
old_preg_o  out  DISP_W x PREG_W  previous mapping of dest (to ROB)
disp_ready_o  out  1  group acceptable this cycle
ckpt_id_o  out  CK_W  checkpoint ID allocated for the branch
cdb_vld_i  in  CDB_W  broadcast valid
cdb_preg_i  in  CDB_W x PREG_W  broadcast tags
rsv_vld_i  in  1  branch resolved
rsv_id_i  in  CK_W  checkpoint of the resolved branch
rsv_mispred_i  in  1  resolved branch mispredicted

Behaviour:
- Reset (async): MAP[i]=i, RDY[i]=1, all checkpoints invalid, all younger masks cleared. Outputs are combinational from state, so at reset disp_ready_o=1 and ckpt_id_o=0.
- Areg 0: always reads preg 0 with ready=1. Writes to areg 0 are dropped, and old_preg_o for them is 0.
- Source read, lane j, in priority order:
  1. The youngest earlier lane k<j in the same group with a valid dest_wr to the same areg gives new_preg_i[k] with rdy=0.
  2. Otherwise MAP gives the preg, and rdy = RDY OR a same-cycle CDB tag match.
- old_preg_o[j]: same intra-group bypass against earlier lanes, otherwise MAP.
- Map update: lanes apply in order, and the later lane wins for the same areg. A written entry gets rdy=0; dispatch beats a CDB in the same cycle on that entry.
- CDB: every entry in MAP and in every valid checkpoint whose preg matches any valid cdb_preg gets RDY=1 next cycle. All ports are applied in parallel.
- Checkpoint allocation:
  - disp_ready_o = !br_vld_i OR any slot free (combinational).
  - On an accepted group with br_vld_i: the lowest free slot k is written with the map/rdy as seen after lanes 0..br_lane_i (inclusive) of this group, with this cycle's CDB applied. ckpt_id_o=k.
  - younger[k] is cleared, and bit k is set in younger[] of every other valid slot.
- Correct resolve (rsv_vld_i, !rsv_mispred_i): slot rsv_id_i is freed and bit rsv_id_i is cleared in all younger masks. The slot is reusable next cycle.
- Mispredict resolve:
  - MAP/RDY are loaded from slot rsv_id_i, with RDY ORed with this cycle's CDB matches.
  - rsv_id_i and every slot in younger[rsv_id_i] are freed.
  - The dispatch group in that cycle is discarded; no allocation happens.
- Resolving an invalid slot: no effect (simulation assertion).
- Reset mid-operation: all checkpoints are discarded immediately.

Optional Feature:
MT_DEBUG_EN:
- Defined: adds dbg_idx_i (AREG_W) in, dbg_preg_o (PREG_W) out, dbg_rdy_o (1) out, and dbg_ckpt_vld_o (CKPT_N) out. These are combinational reads of the architectural-view MAP/RDY and the slot valid bits.
- Undefined: these ports and logic are absent, and functionality is otherwise identical.

Decomposition:
- Shared package rename_pkg: AREG_W, PREG_W, CK_W, LANE_W; typedef map_entry_t {rdy, preg}; typedef map_vec_t [AREG_N] of map_entry_t.
- One sub-module, rename_ckpt_alloc: free mask, lowest-free priority encoder, younger masks, and free/squash logic.
- The map arrays and bypass network stay in the top module.

Test Plan:
- Reset then read areg 5 -> preg 5, rdy 1; areg 0 after a write attempt -> preg 0, rdy 1.
- Group: lane0 r3<-p40, lane1 reads r3 and writes r3<-p41 -> lane1 opa=p40 rdy0, old_preg=p40; next cycle MAP[3]=p41.
- CDB p40 in the same cycle as a dispatch reading an areg mapped to p40 -> rdy=1; a valid checkpoint entry holding p40 is also set ready.
- Branch at lane0 with lane1 writing r7<-p50, then mispredict id0 -> MAP[7] returns to the pre-lane1 value; the dispatch in the mispredict cycle is ignored.
- Allocate checkpoints 0,1,2,3 -> disp_ready_o=0 with br_vld_i=1; mispredict id1 -> slots 1,2,3 freed, next ckpt_id_o=1.
- Correct resolve id0 while a branch group dispatches in the same cycle -> new branch takes the next lowest free slot, and slot 0 is free the following cycle.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared sizes and map-entry types for the rename map table
// and its checkpoint allocator.
package rename_pkg;
    localparam int AREG_N = 32;
    localparam int PREG_N = 64;
    localparam int DISP_W = 2;
    localparam int CDB_W  = 2;
    localparam int CKPT_N = 4;
    localparam int AREG_W = $clog2(AREG_N);
    localparam int PREG_W = $clog2(PREG_N);
    localparam int CK_W   = $clog2(CKPT_N);
    localparam int LANE_W = (DISP_W > 1) ? $clog2(DISP_W) : 1;

    typedef struct packed {
        logic              rdy;
        logic [PREG_W-1:0] preg;
    } map_entry_t;

    typedef map_entry_t [AREG_N-1:0] map_vec_t;

    // Sets rdy on every entry whose preg matches any valid broadcast.
    function automatic map_vec_t cdb_apply(
        input map_vec_t                      m,
        input logic [CDB_W-1:0]              vld,
        input logic [CDB_W-1:0][PREG_W-1:0]  tag
    );
        map_vec_t r;
        r = m;
        for (int a = 0; a < AREG_N; a++)
            for (int c = 0; c < CDB_W; c++)
                if (vld[c] && tag[c] == m[a].preg)
                    r[a].rdy = 1'b1;
        return r;
    endfunction
endpackage

// File: rtl/rename_map_table_if.sv
// Dispatch-side bundle of the rename map table: source/dest
// aregs and free-list pregs in, renamed operands and ckpt ID out.
interface rename_map_table_if;
    import rename_pkg::*;

    logic                           disp_en_i;
    logic [DISP_W-1:0]              lane_vld_i;
    logic [DISP_W-1:0][AREG_W-1:0]  opa_areg_i;
    logic [DISP_W-1:0][AREG_W-1:0]  opb_areg_i;
    logic [DISP_W-1:0][AREG_W-1:0]  dest_areg_i;
    logic [DISP_W-1:0]              dest_wr_i;
    logic [DISP_W-1:0][PREG_W-1:0]  new_preg_i;
    logic                           br_vld_i;
    logic [LANE_W-1:0]              br_lane_i;
    logic [DISP_W-1:0][PREG_W-1:0]  opa_preg_o;
    logic [DISP_W-1:0][PREG_W-1:0]  opb_preg_o;
    logic [DISP_W-1:0]              opa_rdy_o;
    logic [DISP_W-1:0]              opb_rdy_o;
    logic [DISP_W-1:0][PREG_W-1:0]  old_preg_o;
    logic                           disp_ready_o;
    logic [CK_W-1:0]                ckpt_id_o;

    modport master (
        output disp_en_i, lane_vld_i, opa_areg_i, opb_areg_i,
        output dest_areg_i, dest_wr_i, new_preg_i,
        output br_vld_i, br_lane_i,
        input  opa_preg_o, opb_preg_o, opa_rdy_o, opb_rdy_o,
        input  old_preg_o, disp_ready_o, ckpt_id_o
    );

    modport slave (
        input  disp_en_i, lane_vld_i, opa_areg_i, opb_areg_i,
        input  dest_areg_i, dest_wr_i, new_preg_i,
        input  br_vld_i, br_lane_i,
        output opa_preg_o, opb_preg_o, opa_rdy_o, opb_rdy_o,
        output old_preg_o, disp_ready_o, ckpt_id_o
    );
endinterface

// File: rtl/rename_ckpt_alloc.sv
// Checkpoint slot bookkeeping: valid mask, lowest-free pick,
// per-slot younger masks and resolve/squash freeing.
module rename_ckpt_alloc
    import rename_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc,
    input  logic              rsv_vld,
    input  logic [CK_W-1:0]   rsv_id,
    input  logic              rsv_mispred,
    output logic [CKPT_N-1:0] vld,
    output logic              free_any,
    output logic [CK_W-1:0]   free_id
);
    logic [CKPT_N-1:0][CKPT_N-1:0] younger, younger_nxt;
    logic [CKPT_N-1:0]             vld_nxt, kill;

    always_comb begin
        free_any = !(&vld);
        free_id  = '0;
        for (int i = CKPT_N - 1; i >= 0; i--)
            if (!vld[i])
                free_id = CK_W'(i);
    end

    always_comb begin
        kill = '0;
        if (rsv_vld && vld[rsv_id]) begin
            kill[rsv_id] = 1'b1;
            if (rsv_mispred)
                kill = kill | younger[rsv_id];
        end
        vld_nxt     = vld & ~kill;
        younger_nxt = younger;
        if (alloc) begin
            vld_nxt[free_id] = 1'b1;
            for (int i = 0; i < CKPT_N; i++) begin
                if (CK_W'(i) == free_id)
                    younger_nxt[i] = '0;
                else if (vld[i])
                    younger_nxt[i][free_id] = 1'b1;
            end
        end
        // Freed slots must not linger in anyone's squash set.
        for (int i = 0; i < CKPT_N; i++)
            younger_nxt[i] = younger_nxt[i] & ~kill;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld     <= '0;
            younger <= '0;
        end else begin
            vld     <= vld_nxt;
            younger <= younger_nxt;
        end
    end

    a_rsv_live: assert property (
        @(posedge clk) disable iff (rst)
        rsv_vld |-> vld[rsv_id]
    );
endmodule

// File: rtl/rename_map_table.sv
// Superscalar rename map table with internal branch checkpoints.
// Define MT_DEBUG_EN to add the architectural-map debug read port.
module rename_map_table
    import rename_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    rename_map_table_if.slave             dif,
    input  logic [CDB_W-1:0]              cdb_vld_i,
    input  logic [CDB_W-1:0][PREG_W-1:0]  cdb_preg_i,
    input  logic                          rsv_vld_i,
    input  logic [CK_W-1:0]               rsv_id_i,
    input  logic                          rsv_mispred_i
`ifdef MT_DEBUG_EN
    ,
    input  logic [AREG_W-1:0]             dbg_idx_i,
    output logic [PREG_W-1:0]             dbg_preg_o,
    output logic                          dbg_rdy_o,
    output logic [CKPT_N-1:0]             dbg_ckpt_vld_o
`endif
);
    map_vec_t map_q, map_cdb, map_run, snap;
    map_vec_t ckpt_q [CKPT_N];

    logic [CKPT_N-1:0] ck_vld;
    logic              ck_free_any;
    logic [CK_W-1:0]   ck_free_id;
    logic              recover, accept, alloc;
    logic [DISP_W-1:0] lane_wr;

    logic [DISP_W-1:0][PREG_W-1:0] opa_p, opb_p, old_p;
    logic [DISP_W-1:0]             opa_r, opb_r;

    assign recover = rsv_vld_i && rsv_mispred_i && ck_vld[rsv_id_i];
    assign dif.disp_ready_o = !dif.br_vld_i || ck_free_any;
    assign dif.ckpt_id_o    = ck_free_id;
    assign accept = dif.disp_en_i && dif.disp_ready_o && !recover;
    assign alloc  = accept && dif.br_vld_i;

    // Walk lanes in order; each lane sees the map with all
    // earlier lanes' writes, which is the intra-group bypass.
    always_comb begin
        map_cdb    = cdb_apply(map_q, cdb_vld_i, cdb_preg_i);
        map_cdb[0] = '{rdy: 1'b1, preg: '0};
        map_run    = map_cdb;
        snap       = map_cdb;
        opa_p      = '0;
        opb_p      = '0;
        old_p      = '0;
        opa_r      = '0;
        opb_r      = '0;
        lane_wr    = '0;
        for (int j = 0; j < DISP_W; j++) begin
            opa_p[j] = map_run[dif.opa_areg_i[j]].preg;
            opa_r[j] = map_run[dif.opa_areg_i[j]].rdy;
            opb_p[j] = map_run[dif.opb_areg_i[j]].preg;
            opb_r[j] = map_run[dif.opb_areg_i[j]].rdy;
            old_p[j] = map_run[dif.dest_areg_i[j]].preg;
            lane_wr[j] = dif.lane_vld_i[j] && dif.dest_wr_i[j]
                      && dif.dest_areg_i[j] != '0;
            if (lane_wr[j])
                map_run[dif.dest_areg_i[j]] =
                    '{rdy: 1'b0, preg: dif.new_preg_i[j]};
            if (LANE_W'(j) == dif.br_lane_i)
                snap = map_run;
        end
    end

    assign dif.opa_preg_o = opa_p;
    assign dif.opb_preg_o = opb_p;
    assign dif.opa_rdy_o  = opa_r;
    assign dif.opb_rdy_o  = opb_r;
    assign dif.old_preg_o = old_p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < AREG_N; a++)
                map_q[a] <= '{rdy: 1'b1, preg: PREG_W'(a)};
            for (int i = 0; i < CKPT_N; i++)
                ckpt_q[i] <= '0;
        end else begin
            if (recover)
                map_q <= cdb_apply(ckpt_q[rsv_id_i],
                                   cdb_vld_i, cdb_preg_i);
            else if (accept)
                map_q <= map_run;
            else
                map_q <= map_cdb;
            for (int i = 0; i < CKPT_N; i++) begin
                if (alloc && CK_W'(i) == ck_free_id)
                    ckpt_q[i] <= snap;
                else
                    ckpt_q[i] <= cdb_apply(ckpt_q[i],
                                           cdb_vld_i, cdb_preg_i);
            end
        end
    end

    rename_ckpt_alloc u_alloc (
        .clk         (clk),
        .rst         (rst),
        .alloc       (alloc),
        .rsv_vld     (rsv_vld_i),
        .rsv_id      (rsv_id_i),
        .rsv_mispred (rsv_mispred_i),
        .vld         (ck_vld),
        .free_any    (ck_free_any),
        .free_id     (ck_free_id)
    );

`ifdef MT_DEBUG_EN
    assign dbg_preg_o     = map_q[dbg_idx_i].preg;
    assign dbg_rdy_o      = map_q[dbg_idx_i].rdy;
    assign dbg_ckpt_vld_o = ck_vld;
`endif
endmodule
